alu_issue_seq: RTL and testbench

Issue and writeback sequencer that sits directly upstream of the 2-bit combinational ALU, and also captures its results.
- Accepts 9-bit instructions over a valid/ready handshake.
- Reads operands from a 4-entry x 2-bit register file and drives the ALU's a/b/sel inputs.
- Captures the ALU's out/flags, writes the result back, and reports completion.
- Forms the register and control wrapper that turns the ALU into a minimal RISC-style datapath.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_regfile.sv | 28 ++
 rtl/alu_issue_seq.sv | 123 ++++++++++++
 tb/tb_alu_issue_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: widths, opcodes,
// FSM encoding, instruction field positions and flag bit indices.
package alu_pkg;
  localparam int DW   = 2;
  localparam int NREG = 4;
  localparam int RW   = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

  localparam int FLG_ERR = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_CRY = 1;
  localparam int FLG_ZRO = 0;

  // ADD/SUB/AND/OR occupy the lower half of the opcode space
  function automatic logic is_alu_op(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// 4 x DW register file: one synchronous write port, three combinational
// read ports (two operands plus a debug tap).
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] rs1_idx,
  input  logic [RW-1:0] rs2_idx,
  input  logic [RW-1:0] dbg_idx,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [DW-1:0] dbg_data
);
  logic [NREG-1:0][DW-1:0] rf;

  always_ff @(posedge clk) begin
    if (rst)     rf        <= '0;
    else if (we) rf[waddr] <= wdata;
  end

  assign rs1_data = rf[rs1_idx];
  assign rs2_data = rf[rs2_idx];
  assign dbg_data = rf[dbg_idx];
endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer wrapped around a 2-bit combinational ALU.
// Optional retire counter output enabled by ALU_ISSUE_SEQ_RETIRE_CNT_EN.
module alu_issue_seq
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [8:0]    in_instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_error,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  output logic          done,
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  output logic [7:0]    retire_cnt,
`endif
  output logic [3:0]    flags,
  output logic          err_sticky,
  input  logic [RW-1:0] dbg_idx,
  output logic [DW-1:0] dbg_data
);
  state_t        state, state_nxt;
  logic [8:0]    instr_q;
  logic [DW-1:0] result_q;
  logic [3:0]    pend_q;
  logic          rf_we;
  logic [DW-1:0] rs1_data, rs2_data;

  logic [2:0]    op;
  logic [RW-1:0] rd, rs1, rs2;
  assign op  = instr_q[OP_MSB:OP_LSB];
  assign rd  = instr_q[RD_MSB:RD_LSB];
  assign rs1 = instr_q[RS1_MSB:RS1_LSB];
  assign rs2 = instr_q[RS2_MSB:RS2_LSB];

  alu_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (result_q),
    .rs1_idx  (rs1),
    .rs2_idx  (rs2),
    .dbg_idx  (dbg_idx),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    rf_we     = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        // illegal opcodes still reach the ALU so it raises its error flag
        if (is_alu_op(op)) begin
          alu_a   = rs1_data;
          alu_b   = rs2_data;
          alu_sel = op;
        end else if (op != OP_LDI) begin
          alu_sel = op;
        end
        state_nxt = WB;
      end
      WB: begin
        // a reset landing on the WB edge aborts the retire, so no pulse
        done      = ~rst;
        rf_we     = is_alu_op(op) || (op == OP_LDI);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      instr_q    <= '0;
      result_q   <= '0;
      pend_q     <= '0;
      flags      <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) instr_q <= in_instr;
      if (state == EXEC) begin
        if (is_alu_op(op))     result_q <= alu_out;
        else if (op == OP_LDI) result_q <= rs2;
        else                   result_q <= '0;
        pend_q[FLG_ERR] <= alu_error;
        pend_q[FLG_OVF] <= alu_overflow;
        pend_q[FLG_CRY] <= alu_carry;
        pend_q[FLG_ZRO] <= alu_zero;
      end
      if (state == WB) begin
        if (is_alu_op(op))      flags      <= pend_q;
        else if (op != OP_LDI)  err_sticky <= 1'b1;
      end
    end
  end

`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)              retire_cnt <= '0;
    else if (state == WB) retire_cnt <= retire_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: stand-in ALU, per-cycle comparison against a
// transaction-level model, directed literal checks and a random phase.
module tb_alu_issue_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_instr = '0;
  logic       in_ready;
  logic [1:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_error, alu_zero, alu_carry, alu_overflow;
  logic       done;
  logic [3:0] flags;
  logic       err_sticky;
  logic [1:0] dbg_idx = '0;
  logic [1:0] dbg_data;
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  logic [7:0] retire_cnt;
`endif
  logic [5:0] noise = '0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_error    (alu_error),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .done         (done),
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
    .retire_cnt   (retire_cnt),
`endif
    .flags        (flags),
    .err_sticky   (err_sticky),
    .dbg_idx      (dbg_idx),
    .dbg_data     (dbg_data)
  );

  // Stand-in ALU: returns {out[1:0], err, ovf, cry, zro}; overflow only for ADD.
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    logic [1:0] o;
    logic c, v;
    s = '0; o = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[1:0]; c = s[2]; v = (a[1] == b[1]) && (o[1] != a[1]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; o = s[1:0]; c = s[2]; end
      3'd2: o = a & b;
      3'd3: o = a | b;
      default: ;
    endcase
    return {o, (op > 3'd4), v, c, (o == 2'b00)};
  endfunction

  always_comb {alu_out, alu_error, alu_overflow, alu_carry, alu_zero} = alu_fn(alu_sel, alu_a, alu_b) ^ noise;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: age 0 = waiting, 1 = operands in flight, 2 = retiring.
  logic [1:0] rf_m [4];
  logic [3:0] flags_m, pend_m;
  logic [1:0] res_m;
  logic       err_m;
  logic [7:0] cnt_m;
  logic [8:0] ins_m = '0;
  int         age = 0;
  logic       model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (rf_m[i]) rf_m[i] = '0;
      flags_m = '0; pend_m = '0; res_m = '0; err_m = 1'b0; cnt_m = '0;
      age = 0; model_ok = 1'b1;
    end else if (age == 0) begin
      if (in_valid) begin ins_m = in_instr; age = 1; end
    end else if (age == 1) begin
      {res_m, pend_m} = alu_fn(ins_m[8:6], rf_m[ins_m[3:2]], rf_m[ins_m[1:0]]) ^ noise;
      if (ins_m[8:6] == 3'd4) res_m = ins_m[1:0];
      age = 2;
    end else begin
      if (ins_m[8:6] < 3'd4) begin rf_m[ins_m[5:4]] = res_m; flags_m = pend_m; end
      else if (ins_m[8:6] == 3'd4) rf_m[ins_m[5:4]] = res_m;
      else err_m = 1'b1;
      cnt_m = cnt_m + 8'd1;
      age = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [2:0] op;
      op = ins_m[8:6];
      chk("in_ready", in_ready, age == 0);
      chk("done", done, (age == 2) && !rst);
      chk("flags", flags, flags_m);
      chk("err_sticky", err_sticky, err_m);
      chk("dbg_data", dbg_data, rf_m[dbg_idx]);
      chk("alu_sel", alu_sel, (age == 1 && op != 3'd4) ? op : 3'd0);
      if (!(age == 1 && op > 3'd4)) begin
        chk("alu_a", alu_a, (age == 1 && op < 3'd4) ? rf_m[ins_m[3:2]] : 2'd0);
        chk("alu_b", alu_b, (age == 1 && op < 3'd4) ? rf_m[ins_m[1:0]] : 2'd0);
      end
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, cnt_m);
`endif
    end
  end

  logic [1:0] ex_a, ex_b;
  logic [2:0] ex_sel;
  int         lat;

  task automatic issue(input logic [8:0] ins);
    bit got;
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ex_a = alu_a; ex_b = alu_b; ex_sel = alu_sel;
    got = 0; lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
    end
    if (!got) chk("done_timeout", 8'd0, 8'd1);
    chk("done_latency", 8'(lat), 8'd2);
    @(posedge clk); #1;
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [1:0] exp);
    dbg_idx = idx;
    @(negedge clk);
    chk($sformatf("dbg_r%0d", idx), dbg_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_err", err_sticky, 1'b0);
    chk("rst_done", done, 1'b0);

    issue(9'b100_01_00_11);                     // LDI r1,3
    chk_reg(2'd1, 2'd3);
    issue(9'b100_10_00_01);                     // LDI r2,1
    chk_reg(2'd2, 2'd1);
    chk("ldi_flags", flags, 4'b0000);

    issue(9'b000_11_01_10);                     // ADD r3,r1,r2
    chk("add_a", ex_a, 2'd3);
    chk("add_b", ex_b, 2'd1);
    chk("add_sel", ex_sel, 3'b000);
    chk("add_flags", flags, 4'b0011);
    chk_reg(2'd3, 2'd0);

    issue(9'b001_00_10_01);                     // SUB r0,r2,r1
    chk("sub_flags", flags, 4'b0010);
    chk_reg(2'd0, 2'd2);

    issue(9'b010_11_01_10);                     // AND r3,r1,r2
    chk("and_flags", flags, 4'b0000);
    chk_reg(2'd3, 2'd1);
    issue(9'b011_11_11_10);                     // OR r3,r3,r2
    chk("or_flags", flags, 4'b0000);
    chk_reg(2'd3, 2'd1);

    issue(9'b110_01_00_00);                     // illegal, rd=r1
    chk("ill_sel", ex_sel, 3'b110);
    chk("ill_err", err_sticky, 1'b1);
    chk("ill_flags", flags, 4'b0000);
    chk_reg(2'd1, 2'd3);
    issue(9'b100_10_00_01);
    chk("err_holds", err_sticky, 1'b1);

    // reset lands while ADD r1,r1,r1 is in EXEC
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 9'b000_01_01_01;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_done_exec", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err_sticky, 1'b0);
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
    chk("abort_cnt", retire_cnt, 8'd0);
`endif
    for (int r = 0; r < 4; r++) chk_reg(2'(r), 2'd0);

    repeat (3000) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 999) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = 9'($urandom);
      dbg_idx  = 2'($urandom);
      noise    = 6'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; noise = '0;
    repeat (5) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
